bht_sat_predictor: RTL
======================

# bht_sat_predictor

Parametrised branch history table for the CVA6 frontend. It holds one saturating direction counter per instruction slot, with a configurable counter width, entry count and slots per fetch. The table is cleared after reset or flush by a row-sweep state machine. Prediction and update ports serve the frontend and execute stages, generalising the single-bit-per-slot prediction interface to registered, validity-qualified, multi-bit-hysteresis predictions.

## Interface
Parameters:
- `VLEN`, 64, virtual address width.
- `NR_ENTRIES`, 1024, total counters; power of two, at least `INSTR_PER_FETCH`.
- `INSTR_PER_FETCH`, 2, slots per fetch block; power of two.
- `CTR_BITS`, 2, counter width; 1 to 4.
- `ROW_ADDR_OFFSET`, 1, LSBs of PC ignored (1 = halfword, 2 = word).
- Derived: `NR_ROWS = NR_ENTRIES/INSTR_PER_FETCH`; `COL_BITS = log2(INSTR_PER_FETCH)`; `ROW_BITS = log2(NR_ROWS)`.

Ports:
- `clk_i`  in  1  sole clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `flush_i`  in  1  clear the whole table.
- `vpc_i`  in  VLEN  fetch PC to predict.
- `update_valid_i`  in  1  resolved branch update strobe.
- `update_pc_i`  in  VLEN  PC of the resolved branch.
- `update_taken_i`  in  1  resolved direction.
- `pred_valid_o`  out  INSTR_PER_FETCH  per-slot entry-valid flag (registered).
- `pred_taken_o`  out  INSTR_PER_FETCH  per-slot counter MSB (registered).
- `init_busy_o`  out  1  high while the clear sweep is running.

## Operation
- Index: row = `pc[ROW_ADDR_OFFSET+COL_BITS +: ROW_BITS]`; column = `pc[ROW_ADDR_OFFSET +: COL_BITS]`. No tag; aliasing is permitted.
- Each entry holds a valid bit and a `CTR_BITS` counter.
- Prediction: read the entire row selected by `vpc_i`. Register each column's valid bit into `pred_valid_o[c]` and its counter MSB into `pred_taken_o[c]`.
- Update to an invalid entry: set valid. Load `2^(CTR_BITS-1)` if taken, else `2^(CTR_BITS-1)-1`.
- Update to a valid entry: increment if taken, saturating at `2^CTR_BITS-1`. Decrement if not taken, saturating at 0.
- FSM states:
  - INIT: `row_cnt` increments each cycle; each cycle clears the valid bit and counter of every column of row `row_cnt`.
  - READY: normal prediction and update.
- FSM transitions:
  - INIT→READY on the edge that clears row `NR_ROWS-1`.
  - READY→INIT on `flush_i`, with `row_cnt` reset to 0.
  - `flush_i` during INIT restarts the sweep at row 0.
- During INIT: updates are dropped; `pred_valid_o` and `pred_taken_o` register 0.
- `flush_i` and `update_valid_i` in the same cycle: the update is dropped.

## Timing
- Reset: `rst_i` high at an edge forces INIT with `row_cnt=0`, `pred_valid_o=0`, `pred_taken_o=0`, `init_busy_o=1`. No rows are cleared while `rst_i` is held.
- After the first edge with `rst_i` low, the sweep takes exactly `NR_ROWS` edges. `init_busy_o` stays high for `NR_ROWS` cycles, then falls.
- Reset asserted mid-sweep or mid-operation restarts the sweep at row 0.
- Prediction latency is 1 cycle: `vpc_i` sampled at edge N appears on the outputs after edge N.
- Updates are written at the edge where `update_valid_i` is sampled high, and are visible to reads sampled at edge N+1.
- Same-cycle read and update of the same row: by default the read returns the pre-update value (read-before-write). See Configuration.
- Only one update per cycle; there is no update queueing.

## Configuration
- `BHT_UPDATE_BYPASS_EN` defined: a same-cycle update whose row matches the `vpc_i` row is forwarded into the registered prediction for its column. The output shows the post-update valid bit and MSB. Other columns are unaffected.
- Not defined: read-before-write as described above; there is no forwarding logic.

## Test plan
Common parameters: `NR_ENTRIES=16`, `INSTR_PER_FETCH=2`, `CTR_BITS=2`, `ROW_ADDR_OFFSET=1`, giving 8 rows.
- Reset release → `init_busy_o` high exactly 8 cycles. `pred_valid_o=2'b00` for any `vpc_i` during and after the sweep.
- One taken update at `0x1004` (row 1, column 0); read `vpc_i=0x1004` next cycle → `pred_valid_o=2'b01`, `pred_taken_o=2'b01` (counter 2).
- Four taken updates at `0x1004`, then one not-taken → `pred_taken_o[0]=1` (counter 2). A second not-taken → `pred_taken_o[0]=0` (counter 1). Ten further not-taken → counter holds at 0.
- Taken update at `0x1006` after the above → `vpc_i=0x1024` (aliases row 1) returns `pred_valid_o=2'b11` and `pred_taken_o[1]=1`.
- `flush_i` pulse in READY → `init_busy_o` high 8 cycles. A taken update to `0x1004` issued during the sweep is dropped; afterwards `pred_valid_o=2'b00`.
- Reads at `0x1004` with a simultaneous first taken update:
  - Without `BHT_UPDATE_BYPASS_EN` → `pred_valid_o[0]=0`.
  - With it → `pred_valid_o[0]=1`, `pred_taken_o[0]=1`.

Source files
------------

// File: rtl/bht_sat_predictor.sv
// bht_sat_predictor: branch history table of saturating direction counters,
// one per instruction slot. Each row holds INSTR_PER_FETCH entries
// (valid bit + CTR_BITS counter). A row-sweep FSM clears the table after
// reset or flush. Predictions are registered, one cycle after vpc_i.
// Optional feature macro: BHT_UPDATE_BYPASS_EN forwards a same-cycle update
// into the prediction of the matching row/column. When the macro is undefined
// the read is read-before-write.
module bht_sat_predictor #(
  parameter int unsigned VLEN            = 64,
  parameter int unsigned NR_ENTRIES      = 1024,
  parameter int unsigned INSTR_PER_FETCH = 2,
  parameter int unsigned CTR_BITS        = 2,
  parameter int unsigned ROW_ADDR_OFFSET = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       update_valid_i,
  input  logic [VLEN-1:0]            update_pc_i,
  input  logic                       update_taken_i,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic                       init_busy_o
);

  localparam int unsigned NR_ROWS  = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int unsigned COL_BITS = $clog2(INSTR_PER_FETCH);
  localparam int unsigned ROW_BITS = $clog2(NR_ROWS);
  localparam int unsigned COL_W    = (COL_BITS > 0) ? COL_BITS : 1;
  localparam int unsigned ROW_W    = (ROW_BITS > 0) ? ROW_BITS : 1;
  localparam int unsigned ENTRY_W  = CTR_BITS + 1;

  localparam logic [ROW_W-1:0]    ROW_LAST   = ROW_W'(NR_ROWS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE    = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                     r_state;
  state_e                     w_state_next;
  logic [ROW_W-1:0]           r_row_cnt;
  logic [ROW_W-1:0]           w_row_cnt_next;
  logic                       w_clear_en;
  logic                       w_upd_en;
  logic [ROW_W-1:0]           w_rd_row;
  logic [ROW_W-1:0]           w_up_row;
  logic [COL_W-1:0]           w_up_col;
  logic [ENTRY_W-1:0]         w_up_entry [INSTR_PER_FETCH];
  logic [ENTRY_W-1:0]         w_rd_entry [INSTR_PER_FETCH];
  logic [INSTR_PER_FETCH-1:0] w_col_hit;
  logic [ENTRY_W-1:0]         w_old_entry;
  logic [CTR_BITS-1:0]        w_old_ctr;
  logic [ENTRY_W-1:0]         w_new_entry;
  logic [INSTR_PER_FETCH-1:0] r_pred_valid;
  logic [INSTR_PER_FETCH-1:0] r_pred_taken;
  logic                       w_unused_pc;

  // Only the index bits of the PCs select entries; the rest is ignored.
  assign w_unused_pc = ^{vpc_i, update_pc_i};

  if (ROW_BITS > 0) begin : g_row_idx
    assign w_rd_row = vpc_i[ROW_ADDR_OFFSET+COL_BITS +: ROW_BITS];
    assign w_up_row = update_pc_i[ROW_ADDR_OFFSET+COL_BITS +: ROW_BITS];
  end else begin : g_row_zero
    assign w_rd_row = '0;
    assign w_up_row = '0;
  end

  if (COL_BITS > 0) begin : g_col_idx
    assign w_up_col = update_pc_i[ROW_ADDR_OFFSET +: COL_BITS];
  end else begin : g_col_zero
    assign w_up_col = '0;
  end

  // Updates are accepted only in READY, never alongside a flush or reset.
  assign w_upd_en = (r_state == ST_READY) && update_valid_i && !flush_i && !rst_i;

  // State register and sweep row counter; reset restarts the sweep.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_INIT;
      r_row_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_row_cnt <= w_row_cnt_next;
    end
  end

  // Next-state logic: sweep rows in INIT, re-enter the sweep on flush.
  always_comb begin
    w_state_next   = r_state;
    w_row_cnt_next = r_row_cnt;
    w_clear_en     = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clear_en = !rst_i;
        if (flush_i) begin
          w_row_cnt_next = '0;
        end else if (r_row_cnt == ROW_LAST) begin
          w_state_next   = ST_READY;
          w_row_cnt_next = '0;
        end else begin
          w_row_cnt_next = r_row_cnt + ROW_W'(1);
        end
      end
      ST_READY: begin
        if (flush_i) begin
          w_state_next   = ST_INIT;
          w_row_cnt_next = '0;
        end
      end
      default: begin
        w_state_next   = ST_INIT;
        w_row_cnt_next = '0;
      end
    endcase
  end

  // Saturating counter update; a first touch loads the weak state.
  always_comb begin
    w_old_entry = w_up_entry[w_up_col];
    w_old_ctr   = w_old_entry[CTR_BITS-1:0];
    w_new_entry = w_old_entry;
    if (!w_old_entry[CTR_BITS]) begin
      w_new_entry = {1'b1, (update_taken_i ? CTR_WEAK_T : CTR_WEAK_N)};
    end else if (update_taken_i) begin
      if (w_old_ctr != CTR_MAX) begin
        w_new_entry = {1'b1, w_old_ctr + CTR_ONE};
      end
    end else if (w_old_ctr != '0) begin
      w_new_entry = {1'b1, w_old_ctr - CTR_ONE};
    end
  end

  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_col
    logic [ENTRY_W-1:0] r_mem [NR_ROWS];

    assign w_col_hit[gi]  = w_upd_en && (w_up_col == COL_W'(gi));
    assign w_up_entry[gi] = r_mem[w_up_row];

`ifdef BHT_UPDATE_BYPASS_EN
    assign w_rd_entry[gi] = (w_col_hit[gi] && (w_up_row == w_rd_row)) ?
                            w_new_entry : r_mem[w_rd_row];
`else
    assign w_rd_entry[gi] = r_mem[w_rd_row];
`endif

    // Column storage: sweep clear has priority, otherwise the resolved update.
    always_ff @(posedge clk_i) begin
      if (w_clear_en) begin
        r_mem[r_row_cnt] <= '0;
      end else if (w_col_hit[gi]) begin
        r_mem[w_up_row] <= w_new_entry;
      end
    end
  end

  // Registered prediction; forced to zero while reset or sweeping.
  always_ff @(posedge clk_i) begin
    if (rst_i || (r_state != ST_READY)) begin
      r_pred_valid <= '0;
      r_pred_taken <= '0;
    end else begin
      for (int c = 0; c < INSTR_PER_FETCH; c++) begin
        r_pred_valid[c] <= w_rd_entry[c][CTR_BITS];
        r_pred_taken[c] <= w_rd_entry[c][CTR_BITS-1];
      end
    end
  end

  assign pred_valid_o = r_pred_valid;
  assign pred_taken_o = r_pred_taken;
  assign init_busy_o  = (r_state == ST_INIT);

endmodule
